// File: rtl/mips_wb_pkg.sv
// Shared encodings for the MEM/WB writeback stage: source select, load type and FSM state.
package mips_wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LUI  = 2'b10,
        WB_LINK = 2'b11
    } wb_sel_t;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_BU = 3'b001,
        LD_H  = 3'b010,
        LD_HU = 3'b011,
        LD_W  = 3'b100
    } load_type_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_select_unit_load_filter.sv
// Little-endian load lane select with sign/zero extension and alignment check.
module load_filter
    import mips_wb_pkg::*;
#(
    parameter int BITS_SIZE = 32
) (
    input  logic [2:0]           load_type,
    input  logic [1:0]           addr_lsb,
    input  logic [31:0]          mem_word,
    output logic [BITS_SIZE-1:0] load_data,
    output logic                 misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = mem_word[{addr_lsb, 3'b000} +: 8];
    assign lane_half = mem_word[{addr_lsb[1], 4'b0000} +: 16];

    always_comb begin
        load_data  = '0;
        misaligned = 1'b0;
        case (load_type)
            LD_B:  load_data = BITS_SIZE'($signed(lane_byte));
            LD_BU: load_data = BITS_SIZE'(lane_byte);
            LD_H: begin
                load_data  = BITS_SIZE'($signed(lane_half));
                misaligned = addr_lsb[0];
            end
            LD_HU: begin
                load_data  = BITS_SIZE'(lane_half);
                misaligned = addr_lsb[0];
            end
            // LW and all unassigned codes behave as a word load.
            default: begin
                load_data  = BITS_SIZE'($signed(mem_word));
                misaligned = (addr_lsb != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_select_unit.sv
// Registered four-source writeback selector with load filter, memory wait-state
// handshake, timeout fault and flush.
module writeback_select_unit
    import mips_wb_pkg::*;
#(
    parameter int BITS_SIZE     = 32,
    parameter int REG_ADDR_BITS = 5,
    parameter int WAIT_TIMEOUT  = 15
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic [1:0]               i_wb_sel,
    input  logic [2:0]               i_load_type,
    input  logic [1:0]               i_addr_lsb,
    input  logic [BITS_SIZE-1:0]     i_alu_result,
    input  logic [15:0]              i_immediate,
    input  logic [BITS_SIZE-1:0]     i_pc_link,
    input  logic [REG_ADDR_BITS-1:0] i_rd,
    input  logic                     i_reg_write,
    input  logic [BITS_SIZE-1:0]     i_mem_data,
    input  logic                     i_mem_ready,
    input  logic                     i_flush,
    output logic                     o_stall,
    output logic                     o_wb_valid,
    output logic                     o_wb_we,
    output logic [REG_ADDR_BITS-1:0] o_wb_rd,
    output logic [BITS_SIZE-1:0]     o_wb_data,
    output logic                     o_load_fault
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

    wb_state_t              state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   valid_d, we_d, fault_d;
    logic [REG_ADDR_BITS-1:0] rd_d;
    logic [BITS_SIZE-1:0]   data_d;

    logic [BITS_SIZE-1:0]   load_data;
    logic [BITS_SIZE-1:0]   lui_data;
    logic [BITS_SIZE-1:0]   src_data;
    logic                   misaligned;
    logic                   is_mem;
    logic                   write_ok;

    load_filter #(.BITS_SIZE(BITS_SIZE)) u_load_filter (
        .load_type  (i_load_type),
        .addr_lsb   (i_addr_lsb),
        .mem_word   (i_mem_data[31:0]),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign lui_data = BITS_SIZE'($signed({i_immediate, 16'h0000}));
    assign is_mem   = (i_wb_sel == WB_MEM);
    assign write_ok = i_reg_write && (i_rd != '0);

    always_comb begin
        case (i_wb_sel)
            WB_ALU:  src_data = i_alu_result;
            WB_MEM:  src_data = load_data;
            WB_LUI:  src_data = lui_data;
            default: src_data = i_pc_link;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        we_d    = 1'b0;
        fault_d = 1'b0;
        rd_d    = o_wb_rd;
        data_d  = o_wb_data;
        o_stall = 1'b0;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (is_mem && misaligned) begin
                            valid_d = 1'b1;
                            fault_d = 1'b1;
                            rd_d    = i_rd;
                        end else if (is_mem && !i_mem_ready) begin
                            o_stall = 1'b1;
                            state_d = ST_WAIT;
                            cnt_d   = 8'd1;
                        end else begin
                            valid_d = 1'b1;
                            we_d    = write_ok;
                            rd_d    = i_rd;
                            data_d  = src_data;
                        end
                    end
                end
                default: begin
                    // Counter holds the stall cycles already spent; stall is released
                    // on the timeout cycle so upstream retires the faulted load.
                    if (i_mem_ready) begin
                        valid_d = 1'b1;
                        we_d    = write_ok;
                        rd_d    = i_rd;
                        data_d  = src_data;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= TIMEOUT_CNT) begin
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                        rd_d    = i_rd;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        o_stall = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            o_wb_valid   <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_rd      <= '0;
            o_wb_data    <= '0;
            o_load_fault <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_wb_valid   <= valid_d;
            o_wb_we      <= we_d;
            o_wb_rd      <= rd_d;
            o_wb_data    <= data_d;
            o_load_fault <= fault_d;
        end
    end

endmodule

// File: tb/tb_writeback_select_unit.sv
// Bench for writeback_select_unit: 32- and 64-bit instances share stimulus and are
// checked against a transaction-level model of source select, load filter and timeout.
module tb_writeback_select_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ready, flush, rw;
    logic [1:0]  sel, lsb;
    logic [2:0]  lt;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [63:0] alu, pc, mem;

    logic        s32, v32, we32, f32;
    logic [4:0]  rd32;
    logic [31:0] d32;
    logic        s64, v64, we64, f64;
    logic [4:0]  rd64;
    logic [63:0] d64;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_hold = '0;
    logic [4:0]  exp_rd_hold = '0;

    always #5 clk = ~clk;

    writeback_select_unit #(.BITS_SIZE(32), .REG_ADDR_BITS(5), .WAIT_TIMEOUT(T)) u32 (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_wb_sel(sel), .i_load_type(lt),
        .i_addr_lsb(lsb), .i_alu_result(alu[31:0]), .i_immediate(imm), .i_pc_link(pc[31:0]),
        .i_rd(rd), .i_reg_write(rw), .i_mem_data(mem[31:0]), .i_mem_ready(ready),
        .i_flush(flush), .o_stall(s32), .o_wb_valid(v32), .o_wb_we(we32), .o_wb_rd(rd32),
        .o_wb_data(d32), .o_load_fault(f32)
    );

    writeback_select_unit #(.BITS_SIZE(64), .REG_ADDR_BITS(5), .WAIT_TIMEOUT(T)) u64 (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_wb_sel(sel), .i_load_type(lt),
        .i_addr_lsb(lsb), .i_alu_result(alu), .i_immediate(imm), .i_pc_link(pc),
        .i_rd(rd), .i_reg_write(rw), .i_mem_data(mem), .i_mem_ready(ready),
        .i_flush(flush), .o_stall(s64), .o_wb_valid(v64), .o_wb_we(we64), .o_wb_rd(rd64),
        .o_wb_data(d64), .o_load_fault(f64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_misaligned(input logic [2:0] t, input logic [1:0] l);
        int tv = int'(t);
        int lv = int'(l);
        if (tv == 2 || tv == 3) return (lv % 2) == 1;
        if (tv >= 4) return lv != 0;
        return 1'b0;
    endfunction

    // Value the register file should receive, always in 64-bit sign-extended form.
    function automatic logic [63:0] model_data(input logic [1:0] s, input logic [2:0] t,
                                               input logic [1:0] l, input logic [63:0] a,
                                               input logic [15:0] im, input logic [63:0] p,
                                               input logic [31:0] m);
        longint v;
        longint two32 = longint'(1) <<< 32;
        longint b = longint'((m >> (int'(l) * 8)) & 32'hFF);
        longint h = longint'((m >> ((int'(l) / 2) * 16)) & 32'hFFFF);
        longint w = longint'(m);
        case (int'(s))
            0: return a;
            3: return p;
            2: begin
                v = longint'(im) * 65536;
                if (im >= 16'h8000) v = v - two32;
                return 64'(v);
            end
            default: begin
                case (int'(t))
                    0: v = (b >= 128) ? b - 256 : b;
                    1: v = b;
                    2: v = (h >= 32768) ? h - 65536 : h;
                    3: v = h;
                    default: v = (w >= (two32 / 2)) ? w - two32 : w;
                endcase
                return 64'(v);
            end
        endcase
    endfunction

    // d = number of leading cycles with i_mem_ready low for an aligned load.
    task automatic run_txn(input string tag, input logic [1:0] s, input logic [2:0] t,
                           input logic [1:0] l, input logic [63:0] a, input logic [15:0] im,
                           input logic [63:0] p, input logic [63:0] m, input logic [4:0] r,
                           input logic w, input int d);
        bit is_mem = (s == 2'b01);
        bit mis = is_mem && model_misaligned(t, l);
        bit wait_mem = is_mem && !mis;
        int exp_stalls = !wait_mem ? 0 : ((d <= T) ? d : T);
        bit exp_fault = mis || (wait_mem && d > T);
        bit exp_we = w && (r != 5'd0) && !exp_fault;
        logic [63:0] exp_d = model_data(s, t, l, a, im, p, m[31:0]);
        int st32 = 0;
        int st64 = 0;
        int k = 0;
        bit stalled;
        sel = s; lt = t; lsb = l; alu = a; imm = im; pc = p; mem = m; rd = r; rw = w;
        valid = 1'b1;
        ready = wait_mem ? (d == 0) : 1'($urandom_range(0, 1));
        forever begin
            @(negedge clk);
            stalled = s32;
            st32 += int'(s32);
            st64 += int'(s64);
            @(posedge clk);
            if (!stalled) break;
            k++;
            if (k > 40) begin
                checks++;
                errors++;
                $error("FAIL %s_hang stall_cycles=%0d limit=40", tag, k);
                break;
            end
            #1;
            if (wait_mem) ready = (k >= d);
        end
        #1;
        valid = 1'b0;
        check({tag, "_stall32"}, 64'(st32), 64'(exp_stalls));
        check({tag, "_stall64"}, 64'(st64), 64'(exp_stalls));
        check({tag, "_v32"}, 64'(v32), 64'd1);
        check({tag, "_v64"}, 64'(v64), 64'd1);
        check({tag, "_we32"}, 64'(we32), 64'(exp_we));
        check({tag, "_we64"}, 64'(we64), 64'(exp_we));
        check({tag, "_f32"}, 64'(f32), 64'(exp_fault));
        check({tag, "_f64"}, 64'(f64), 64'(exp_fault));
        check({tag, "_rd32"}, 64'(rd32), 64'(r));
        check({tag, "_rd64"}, 64'(rd64), 64'(r));
        if (!exp_fault) begin
            check({tag, "_d32"}, 64'(d32), 64'(exp_d[31:0]));
            check({tag, "_d64"}, d64, exp_d);
            exp_hold = exp_d;
        end
        exp_rd_hold = r;
    endtask

    task automatic idle_cycle(input string tag);
        valid = 1'b0;
        ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check({tag, "_v32"}, 64'(v32), 64'd0);
        check({tag, "_we64"}, 64'(we64), 64'd0);
        check({tag, "_f32"}, 64'(f32), 64'd0);
        check({tag, "_d32"}, 64'(d32), 64'(exp_hold[31:0]));
        check({tag, "_d64"}, d64, exp_hold);
        check({tag, "_rd32"}, 64'(rd32), 64'(exp_rd_hold));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; ready = 1'b0; rw = 1'b0;
        sel = '0; lt = '0; lsb = '0; imm = '0; rd = '0; alu = '0; pc = '0; mem = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_v32", 64'(v32), 64'd0);
        check("rst_we32", 64'(we32), 64'd0);
        check("rst_f32", 64'(f32), 64'd0);
        check("rst_d64", d64, 64'd0);
        check("rst_rd64", 64'(rd64), 64'd0);
        check("rst_stall", 64'(s32), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_txn("lui", 2'b10, 3'd0, 2'd0, 64'h1, 16'h8001, 64'h2, 64'h0, 5'd3, 1'b1, 0);
        run_txn("lb2", 2'b01, 3'd0, 2'd2, 64'h0, 16'h0, 64'h0, 64'h80FF7F01, 5'd4, 1'b1, 0);
        run_txn("lbu3", 2'b01, 3'd1, 2'd3, 64'h0, 16'h0, 64'h0, 64'h80FF7F01, 5'd5, 1'b1, 0);
        run_txn("lh0", 2'b01, 3'd2, 2'd0, 64'h0, 16'h0, 64'h0, 64'h80FF7F01, 5'd6, 1'b1, 0);
        run_txn("lhu2", 2'b01, 3'd3, 2'd2, 64'h0, 16'h0, 64'h0, 64'h80FF7F01, 5'd7, 1'b1, 0);
        run_txn("lw_mis", 2'b01, 3'd4, 2'd2, 64'h0, 16'h0, 64'h0, 64'h12345678, 5'd8, 1'b1, 0);
        run_txn("lh_mis", 2'b01, 3'd2, 2'd1, 64'h0, 16'h0, 64'h0, 64'h12345678, 5'd9, 1'b1, 0);
        idle_cycle("after_mis");
        run_txn("lw_wait3", 2'b01, 3'd4, 2'd0, 64'h0, 16'h0, 64'h0, 64'hDEADBEEF, 5'd10, 1'b1, 3);
        run_txn("lw_tmo", 2'b01, 3'd4, 2'd0, 64'h0, 16'h0, 64'h0, 64'h0BADF00D, 5'd11, 1'b1, 100);
        run_txn("lw_edge", 2'b01, 3'd4, 2'd0, 64'h0, 16'h0, 64'h0, 64'h7654ABCD, 5'd12, 1'b1, T);
        run_txn("rd0", 2'b00, 3'd0, 2'd0, 64'hCAFE, 16'h0, 64'h0, 64'h0, 5'd0, 1'b1, 0);
        run_txn("link", 2'b11, 3'd0, 2'd0, 64'h0, 16'h0, 64'hFFFF_0000_0000_1234, 64'h0, 5'd31, 1'b1, 0);
        idle_cycle("idle1");

        // Flush on the second cycle spent in WAIT.
        sel = 2'b01; lt = 3'd4; lsb = 2'd0; mem = 64'h11112222; rd = 5'd13; rw = 1'b1;
        valid = 1'b1; ready = 1'b0;
        @(negedge clk);
        check("fl_s0", 64'(s32), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("fl_s1", 64'(s64), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_drop32", 64'(s32), 64'd0);
        check("fl_drop64", 64'(s64), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        check("fl_v32", 64'(v32), 64'd0);
        check("fl_we64", 64'(we64), 64'd0);
        check("fl_f32", 64'(f32), 64'd0);
        run_txn("fl_alu", 2'b00, 3'd0, 2'd0, 64'h0000_0001_5A5A_A5A5, 16'h0, 64'h0, 64'h0, 5'd9, 1'b1, 0);

        // Reset while waiting for memory.
        sel = 2'b01; lt = 3'd4; lsb = 2'd0; mem = 64'h33334444; rd = 5'd14; rw = 1'b1;
        valid = 1'b1; ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        valid = 1'b0;
        #1;
        check("mr_v32", 64'(v32), 64'd0);
        check("mr_we32", 64'(we32), 64'd0);
        check("mr_f64", 64'(f64), 64'd0);
        check("mr_rd32", 64'(rd32), 64'd0);
        check("mr_d32", 64'(d32), 64'd0);
        check("mr_d64", d64, 64'd0);
        check("mr_stall", 64'(s32), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_hold = '0;
        exp_rd_hold = '0;
        idle_cycle("mr_after");

        for (int i = 0; i < 80; i++) begin
            logic [1:0]  rs = 2'($urandom_range(0, 3));
            logic [2:0]  rt = 3'($urandom_range(0, 7));
            logic [1:0]  rl = 2'($urandom_range(0, 3));
            logic [63:0] ra = {32'($urandom), 32'($urandom)};
            logic [63:0] rp = {32'($urandom), 32'($urandom)};
            logic [63:0] rm = {32'($urandom), 32'($urandom)};
            logic [15:0] ri = 16'($urandom);
            logic [4:0]  rr = 5'($urandom_range(0, 31));
            logic        rwv = 1'($urandom_range(0, 3) != 0);
            int          rd_delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            if ($urandom_range(0, 5) == 0) idle_cycle("rnd_idle");
            run_txn("rnd", rs, rt, rl, ra, ri, rp, rm, rr, rwv, rd_delay);
        end
        idle_cycle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
